// File: rtl/mem_pkg.sv
// Shared definitions for the word-oriented memory controller and its backing store.
package mem_pkg;

    localparam int unsigned DEFAULT_LATENCY   = 4;
    localparam int unsigned DEFAULT_MEM_BYTES = 65536;

    // Wide enough for the largest legal latency count (LATENCY-1 <= 14).
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_t;

endpackage

// File: rtl/byte_mem.sv
// Byte-addressed backing store with word-wide per-byte write enables and a registered read.
module byte_mem
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES,
    localparam int unsigned IDX_W    = $clog2(MEM_BYTES / 4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:3]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata [0:3],
    input  logic             re,
    output logic [7:0]       rdata [0:3]
);

    // Contents start at zero and are deliberately untouched by reset.
    logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
    logic [7:0] rdata_q [0:3];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[{idx, 2'(i)}] <= wdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '{default: 8'h00};
        end else if (re) begin
            for (int i = 0; i < 4; i++) begin
                rdata_q[i] <= mem[{idx, 2'(i)}];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Fixed-latency single-outstanding memory controller: accept, wait LATENCY cycles, respond.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY   = DEFAULT_LATENCY,
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_wdata [0:3],
    output logic        req_ready,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata [0:3],
    input  logic        resp_ready
);

    localparam int unsigned       IDX_W    = $clog2(MEM_BYTES / 4);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         wdata_q [0:3];
    logic               resp_valid_q;
    logic [7:0]         resp_rdata_q [0:3];

    logic               accept;
    logic               commit;
    logic [0:3]         mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [7:0]         mem_rdata [0:3];
    logic               unused_addr;

    assign req_ready   = reset && (state_q == StIdle);
    assign accept      = req_valid && req_ready;
    assign commit      = (state_q == StWait) && (cnt_q == '0);
    assign mem_we      = {4{commit && we_q}};
    // The read is launched at acceptance so its registered data is ready by the WAIT exit.
    assign mem_idx     = (state_q == StIdle) ? req_addr[IDX_W+1:2] : idx_q;
    assign unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = CNT_LOAD;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '{default: 8'h00};
        end else if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '{default: 8'h00};
        end else if (commit) begin
            resp_valid_q <= 1'b1;
            if (we_q) begin
                resp_rdata_q <= wdata_q;
            end else begin
                resp_rdata_q <= mem_rdata;
            end
        end else if ((state_q == StResp) && resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    byte_mem #(
        .MEM_BYTES (MEM_BYTES)
    ) u_byte_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .idx   (mem_idx),
        .wdata (wdata_q),
        .re    (accept),
        .rdata (mem_rdata)
    );

endmodule
